// File: rtl/return_address_stack.sv
// Return address stack: circular LUT-RAM buffer of call return addresses with
// saturating occupancy count and snapshot/restore of the pointer state on flush.
module return_address_stack #(
    parameter  int RAS_ENTRIES = 8,
    localparam int IDX_W       = $clog2(RAS_ENTRIES),
    localparam int SNAP_W      = 2*IDX_W+1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [31:0]       push_addr,
    input  logic              pop,
    output logic [31:0]       pop_addr,
    output logic              valid,
    output logic [SNAP_W-1:0] snapshot,
    input  logic              restore,
    input  logic [SNAP_W-1:0] restore_snapshot
);

    localparam logic [IDX_W:0] FULL      = (IDX_W+1)'(RAS_ENTRIES);
    localparam logic [IDX_W:0] COUNT_ONE = (IDX_W+1)'(1);

    logic [31:0]      lut [RAS_ENTRIES];
    logic [IDX_W-1:0] read_index_reg, read_index_next;
    logic [IDX_W:0]   count_reg, count_next;
    logic             lut_we;
    logic [IDX_W-1:0] lut_waddr;
    logic [IDX_W:0]   restore_count;
    logic [IDX_W-1:0] restore_index;

    assign {restore_count, restore_index} = restore_snapshot;

    always_comb begin
        read_index_next = read_index_reg;
        count_next      = count_reg;
        lut_we          = 1'b0;
        lut_waddr       = read_index_reg + 1'b1;
        if (restore) begin
            // A corrupted snapshot must never claim more entries than exist
            count_next      = (restore_count > FULL) ? FULL : restore_count;
            read_index_next = restore_index;
        end else if (push && pop) begin
            // Return immediately followed by a call: replace the top in place
            lut_we     = 1'b1;
            lut_waddr  = read_index_reg;
            count_next = (count_reg == '0) ? COUNT_ONE : count_reg;
        end else if (push) begin
            lut_we          = 1'b1;
            read_index_next = read_index_reg + 1'b1;
            count_next      = (count_reg == FULL) ? FULL : count_reg + 1'b1;
        end else if (pop && (count_reg != '0)) begin
            read_index_next = read_index_reg - 1'b1;
            count_next      = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_index_reg <= '0;
            count_reg      <= '0;
        end else begin
            read_index_reg <= read_index_next;
            count_reg      <= count_next;
        end
    end

    // Storage is deliberately not reset; entries are only meaningful below count
    always_ff @(posedge clk) begin
        if (lut_we && !rst)
            lut[lut_waddr] <= push_addr;
    end

    assign valid    = (count_reg != '0);
    assign pop_addr = valid ? lut[read_index_reg] : 32'h0;
    assign snapshot = {count_reg, read_index_reg};

endmodule

// File: tb/tb_return_address_stack.sv
// Directed bench for return_address_stack: a vector table of single-cycle
// operations with expected outputs, plus a hand-written asynchronous reset sequence.
module tb_return_address_stack;

    logic        clk = 1'b0;
    logic        rst;
    logic        push;
    logic [31:0] push_addr;
    logic        pop;
    logic [31:0] pop_addr;
    logic        valid;
    logic [6:0]  snapshot;
    logic        restore;
    logic [6:0]  restore_snapshot;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    return_address_stack #(.RAS_ENTRIES(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .push             (push),
        .push_addr        (push_addr),
        .pop              (pop),
        .pop_addr         (pop_addr),
        .valid            (valid),
        .snapshot         (snapshot),
        .restore          (restore),
        .restore_snapshot (restore_snapshot)
    );

    typedef struct {
        string       name;
        logic        push;
        logic [31:0] addr;
        logic        pop;
        logic        restore;
        logic [6:0]  rsnap;
        logic        ev;
        logic [31:0] ea;
        logic [6:0]  es;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [6:0] sn(int c, int r);
        return {4'(c), 3'(r)};
    endfunction

    function automatic void add(string name, logic pu, logic [31:0] a, logic po,
                                logic rs, logic [6:0] rsn,
                                logic ev, logic [31:0] ea, logic [6:0] es);
        vec_t v;
        v.name = name; v.push = pu; v.addr = a; v.pop = po; v.restore = rs;
        v.rsnap = rsn; v.ev = ev; v.ea = ea; v.es = es;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic ev, logic [31:0] ea, logic [6:0] es);
        n_checks++;
        if (valid !== ev || pop_addr !== ea || snapshot !== es) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b pop_addr=%h snapshot=%h, expected valid=%0b pop_addr=%h snapshot=%h",
                     name, valid, pop_addr, snapshot, ev, ea, es);
        end else begin
            $display("ok   %s: valid=%0b pop_addr=%h snapshot=%h", name, valid, pop_addr, snapshot);
        end
    endtask

    task automatic idle();
        push = 1'b0; push_addr = 32'h0; pop = 1'b0;
        restore = 1'b0; restore_snapshot = 7'h0;
    endtask

    initial begin
        // Basic push/pop
        add("b_push100", 1, 32'h100, 0, 0, 0, 1, 32'h100, sn(1,1));
        add("b_push200", 1, 32'h200, 0, 0, 0, 1, 32'h200, sn(2,2));
        add("b_pop1",    0, 0,       1, 0, 0, 1, 32'h100, sn(1,1));
        add("b_pop2",    0, 0,       1, 0, 0, 0, 32'h0,   sn(0,0));
        // Overflow: nine pushes into eight entries, 0x90 overwrites 0x10
        for (int i = 1; i <= 9; i++)
            add($sformatf("ovf_push%0d", i), 1, 32'(i*16), 0, 0, 0, 1, 32'(i*16),
                sn(i > 8 ? 8 : i, i % 8));
        for (int k = 1; k <= 7; k++)
            add($sformatf("ovf_pop%0d", k), 0, 0, 1, 0, 0, 1, 32'((9-k)*16),
                sn(8-k, (9-k) % 8));
        add("ovf_pop8",   0, 0, 1, 0, 0, 0, 32'h0, sn(0,1));
        // Underflow and push+pop on empty
        add("udf_pop",     0, 0,      1, 0, 0, 0, 32'h0,  sn(0,1));
        add("empty_pp44",  1, 32'h44, 1, 0, 0, 1, 32'h44, sn(1,1));
        add("drain44",     0, 0,      1, 0, 0, 0, 32'h0,  sn(0,0));
        // Simultaneous push+pop on {0x100, 0x200}
        add("pp_push100",  1, 32'h100, 0, 0, 0, 1, 32'h100, sn(1,1));
        add("pp_push200",  1, 32'h200, 0, 0, 0, 1, 32'h200, sn(2,2));
        add("pp_pp300",    1, 32'h300, 1, 0, 0, 1, 32'h300, sn(2,2));
        add("pp_pop",      0, 0,       1, 0, 0, 1, 32'h100, sn(1,1));
        add("pp_drain",    0, 0,       1, 0, 0, 0, 32'h0,   sn(0,0));
        // Snapshot/restore: S = {1,1} after pushing 0xA
        add("sr_pushA",    1, 32'hA, 0, 0, 0, 1, 32'hA, sn(1,1));
        add("sr_pushB",    1, 32'hB, 0, 0, 0, 1, 32'hB, sn(2,2));
        add("sr_pushC",    1, 32'hC, 0, 0, 0, 1, 32'hC, sn(3,3));
        add("sr_pop",      0, 0,     1, 0, 0, 1, 32'hB, sn(2,2));
        add("sr_restoreS", 1, 32'hD, 0, 1, sn(1,1), 1, 32'hA, sn(1,1));
        // Slot 3 would have received 0xD had the restore cycle written
        add("sr_noD",      0, 0,     1, 1, sn(3,3), 1, 32'hC, sn(3,3));
        add("sr_clamp",    1, 32'hEE, 1, 1, sn(15,5), 1, 32'h50, sn(8,5));
        add("sr_zero",     0, 0,     0, 1, sn(0,5), 0, 32'h0, sn(0,5));
        add("sr_cnt3",     0, 0,     0, 1, sn(3,3), 1, 32'hC, sn(3,3));

        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 0, 32'h0, 7'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            push = vecs[i].push; push_addr = vecs[i].addr; pop = vecs[i].pop;
            restore = vecs[i].restore; restore_snapshot = vecs[i].rsnap;
            @(posedge clk);
            #1;
            idle();
            check(vecs[i].name, vecs[i].ev, vecs[i].ea, vecs[i].es);
        end

        // Async reset mid-cycle with count=3 and a push pending
        #2;
        push = 1'b1; push_addr = 32'h77;
        rst = 1'b1;
        #1;
        check("arst_immediate", 0, 32'h0, 7'h0);
        @(posedge clk);
        #1;
        check("arst_held_push", 0, 32'h0, 7'h0);
        @(negedge clk);
        rst = 1'b0;
        push = 1'b1; push_addr = 32'h5;
        @(posedge clk);
        #1;
        idle();
        check("arst_push5", 1, 32'h5, sn(1,1));
        @(posedge clk);
        #1;
        check("arst_hold", 1, 32'h5, sn(1,1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/return_address_stack.md
RETURN_ADDRESS_STACK -- requirements
Module: return_address_stack

Interface
REQ-001 SHALL have parameter RAS_ENTRIES, default 8: stack depth; power of two, minimum 2; sourced from the branch predictor configuration field RAS_ENTRIES.
REQ-002 SHALL derive localparam IDX_W = $clog2(RAS_ENTRIES) and localparam SNAP_W = 2*IDX_W+1.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port push, input, 1: call detected; push push_addr.
REQ-006 SHALL have port push_addr, input, 32: return address to store.
REQ-007 SHALL have port pop, input, 1: return detected; consume the top entry.
REQ-008 SHALL have port pop_addr, output, 32: predicted return address, which is the current top of stack.
REQ-009 SHALL have port valid, output, 1: stack non-empty.
REQ-010 SHALL have port snapshot, output, SNAP_W: the current {count, read_index}, captured by the branch unit at issue.
REQ-011 SHALL have port restore, input, 1: misprediction flush; restore the pointers.
REQ-012 SHALL have port restore_snapshot, input, SNAP_W: the pointer state to restore.

Function
REQ-013 SHALL store entries in a RAS_ENTRIES x 32 LUT-RAM circular buffer with one write port and one combinational read port.
REQ-014 SHALL hold state in two registers:
- read_index: IDX_W bits, the top entry.
- count: IDX_W+1 bits, saturating at RAS_ENTRIES.
REQ-015 SHALL drive valid = (count != 0) combinationally.
REQ-016 SHALL drive pop_addr as follows:
- when valid=1: lut[read_index], combinational (zero-cycle latency).
- when valid=0: 32'h0.
REQ-017 SHALL drive snapshot = {count, read_index}, combinational.
REQ-018 On push only, SHALL:
- write lut[read_index+1] = push_addr (index modulo RAS_ENTRIES);
- set read_index += 1 (wrapping);
- set count = min(count+1, RAS_ENTRIES).
REQ-019 On push when count == RAS_ENTRIES, SHALL overwrite the oldest entry silently; count stays RAS_ENTRIES.
REQ-020 On pop only with count != 0, SHALL set read_index -= 1 (wrapping) and count -= 1.
REQ-021 On pop only with count == 0, SHALL make no state change (underflow ignored).
REQ-022 On push and pop in the same cycle, SHALL:
- write lut[read_index] = push_addr;
- leave read_index unchanged;
- leave count unchanged if it is nonzero, otherwise set it to 1.
REQ-023 On restore, SHALL load {count, read_index} from restore_snapshot, with priority over push and pop that cycle.
REQ-024 On restore, SHALL perform no LUT write and leave LUT contents unchanged.
REQ-025 When restore_snapshot carries a count field greater than RAS_ENTRIES, SHALL clamp the loaded count to RAS_ENTRIES.
REQ-026 SHALL make a written entry visible on pop_addr in the cycle after the write; no same-cycle bypass.
REQ-027 SHALL contain no combinational path from push, pop or restore to any output.

Reset
REQ-028 While rst=1, SHALL force read_index=0 and count=0, so that valid=0, pop_addr=32'h0 and snapshot=0.
REQ-029 SHALL NOT reset LUT contents.
REQ-030 SHALL apply assertion of rst mid-operation immediately, regardless of push, pop or restore.
REQ-031 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Verification
REQ-032 Basic push/pop: push 0x100, then push 0x200 -> pop_addr=0x200 and valid=1. Pop -> pop_addr=0x100. Pop -> valid=0 and pop_addr=0.
REQ-033 Overflow (RAS_ENTRIES=8): push 0x10..0x90 (9 pushes) -> count=8 and pop_addr=0x90. After 8 pops the last pop_addr seen is 0x20 and valid=0.
REQ-034 Simultaneous push+pop: stack {0x100, 0x200}, push 0x300 with pop -> pop_addr=0x300 and count=2. Then pop -> pop_addr=0x100.
REQ-035 Empty push+pop and underflow: pop on empty -> no change and valid=0. Push 0x44 with pop on empty -> valid=1, pop_addr=0x44, count=1.
REQ-036 Snapshot/restore:
- push 0xA, capture snapshot S;
- push 0xB, 0xC; pop;
- assert restore=1 with S, together with push 0xD -> next cycle pop_addr=0xA, count=1, and no write of 0xD.
REQ-037 Async reset: assert rst between clock edges with count=3 -> valid=0 and pop_addr=0 before the next clk edge. After release, push 0x5 -> pop_addr=0x5.
